// File: rtl/enc_4_2_seq_pkg.sv
// enc_pkg: shared constants, FSM state type and popcount helper for enc_4_2_seq
package enc_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = $clog2(N_REQ);
  typedef enum logic {IDLE, PRESENT} state_t;
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/enc_4_2_seq_if.sv
// enc_4_2_seq_if: request inputs and valid/ready index output of the encoder
interface enc_4_2_seq_if;
  import enc_pkg::*;
  logic [N_REQ-1:0] req;
  logic             out_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic             out_multi;
  logic [N_REQ-1:0] pending;
  logic             ovf;
  modport master (input req, out_ready, output out_valid, out_idx, out_multi, pending, ovf);
  modport slave (output req, out_ready, input out_valid, out_idx, out_multi, pending, ovf);
endinterface

// File: rtl/enc_prio4.sv
// enc_prio4: combinational 4-bit priority encoder, bit 3 highest
module enc_prio4 (
  input  logic [3:0] vec,
  output logic [1:0] idx,
  output logic       any
);
  // highest-numbered set bit wins; idx is 0 when nothing is set
  always_comb begin
    idx = vec[3] ? 2'd3 : vec[2] ? 2'd2 : vec[1] ? 2'd1 : 2'd0;
    any = |vec;
  end
endmodule

// File: rtl/enc_4_2_seq.sv
// enc_4_2_seq: registered 4-to-2 priority encoder with sticky capture and valid/ready output
module enc_4_2_seq
  import enc_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  enc_4_2_seq_if.master  bus
);
  state_t           state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d, clr;
  logic [IDX_W-1:0] idx_q, idx_d, p_idx, r_idx;
  logic             multi_q, multi_d, ovf_q, ovf_d, p_any, r_any, acc;
  assign acc = (state_q == PRESENT) && bus.out_ready;
  assign clr = acc ? (N_REQ'(1) << idx_q) : '0;
  // capture requests (set beats clear) and flag requests landing on uncleared pending bits
  always_comb begin
    pending_d = (pending_q & ~clr) | bus.req;
    ovf_d     = ovf_q | (|(bus.req & pending_q & ~clr));
  end
  enc_prio4 u_pend (.vec(pending_q), .idx(p_idx), .any(p_any));
  enc_prio4 u_rem (.vec(pending_d), .idx(r_idx), .any(r_any));
  // load from pending when idle; on accept reload from the remaining set or fall idle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    multi_d = multi_q;
    if (state_q == IDLE) begin
      if (p_any) begin
        state_d = PRESENT;
        idx_d   = p_idx;
        multi_d = popcount4(pending_q) > 3'd1;
      end
    end else if (acc) begin
      if (r_any) begin
        idx_d   = r_idx;
        multi_d = popcount4(pending_d) > 3'd1;
      end else begin
        state_d = IDLE;
      end
    end
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      multi_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      multi_q   <= multi_d;
      ovf_q     <= ovf_d;
    end
  end
  assign bus.out_valid = state_q == PRESENT;
  assign bus.out_idx   = idx_q;
  assign bus.out_multi = multi_q;
  assign bus.pending   = pending_q;
  assign bus.ovf       = ovf_q;
endmodule
